// File: rtl/amber_ar_pkg.sv
// Shared types for the amber address-register ALU: op codes, flag bit positions
// and the per-stage control payload carried alongside the AR/DR data words.
package amber_ar_pkg;

  typedef enum logic [3:0] {
    OP_MOVA  = 4'd0,
    OP_MOVD  = 4'd1,
    OP_ADDAU = 4'd2,
    OP_SUBAU = 4'd3,
    OP_ADDAS = 4'd4,
    OP_SUBAS = 4'd5,
    OP_ADDAI = 4'd6,
    OP_SUBAI = 4'd7,
    OP_LEA   = 4'd8,
    OP_LDA   = 4'd9,
    OP_ADR   = 4'd10,
    OP_CMPA  = 4'd11,
    OP_TSTA  = 4'd12
  } ar_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic [7:0] tag;
    logic       ar_we;
    logic       gp_we;
    logic       sr_we;
    logic       fault;
    logic [3:0] flags;
  } ar_ctrl_t;

endpackage

// File: rtl/ar_alu_core.sv
// Combinational stage-1 datapath of the AR ALU: decode, operand extension,
// ADDR_W+1 add/sub, flags and (with AMBER_AR_WRAP_TRAP_EN) address wrap detection.
module ar_alu_core
  import amber_ar_pkg::*;
#(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 24,
  parameter int IMM_W  = 14
) (
  input  ar_op_t              op,
  input  logic                half,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [IMM_W-1:0]    imm,
  input  logic [DATA_W-1:0]   src_gp,
  input  logic [ADDR_W-1:0]   src_ar,
  input  logic [ADDR_W-1:0]   tgt_ar,
  output logic [ADDR_W-1:0]   ar_result,
  output logic [DATA_W-1:0]   result,
  output logic [3:0]          flags,
  output logic                ar_we,
  output logic                gp_we,
  output logic                sr_we,
  output logic                fault
);

  function automatic logic ovf(input logic a_msb, input logic b_msb,
                               input logic r_msb, input logic is_sub);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else        return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  logic signed [ADDR_W-1:0] gp_sx;
  logic signed [ADDR_W-1:0] imm_sx;
  logic        [ADDR_W-1:0] gp_zx;
  logic signed [ADDR_W-1:0] opa;
  logic signed [ADDR_W-1:0] opb;
  logic signed [ADDR_W-1:0] res;
  logic        [ADDR_W-1:0] mov_ar;
  logic        [ADDR_W:0]   wide;
  logic                     sub;
  logic                     arith;
  logic                     use_mov;
  logic                     ar_we_d;
  logic                     v_flag;

  assign gp_sx  = {{(ADDR_W-DATA_W){src_gp[DATA_W-1]}}, src_gp};
  assign gp_zx  = {{(ADDR_W-DATA_W){1'b0}}, src_gp};
  assign imm_sx = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    opa     = '0;
    opb     = '0;
    sub     = 1'b0;
    arith   = 1'b0;
    use_mov = 1'b0;
    mov_ar  = '0;
    result  = '0;
    ar_we_d = 1'b0;
    gp_we   = 1'b0;
    sr_we   = 1'b0;
    case (op)
      OP_MOVA: begin
        use_mov = 1'b1;
        mov_ar  = half ? {src_gp, tgt_ar[DATA_W-1:0]} : {tgt_ar[ADDR_W-1:DATA_W], src_gp};
        ar_we_d = 1'b1;
      end
      OP_MOVD: begin
        result = half ? src_ar[ADDR_W-1:DATA_W] : src_ar[DATA_W-1:0];
        gp_we  = 1'b1;
      end
      OP_ADDAU: begin opa = tgt_ar; opb = gp_zx;  arith = 1'b1; ar_we_d = 1'b1; end
      OP_SUBAU: begin opa = tgt_ar; opb = gp_zx;  sub = 1'b1; arith = 1'b1; ar_we_d = 1'b1; end
      OP_ADDAS: begin opa = tgt_ar; opb = gp_sx;  arith = 1'b1; ar_we_d = 1'b1; end
      OP_SUBAS: begin opa = tgt_ar; opb = gp_sx;  sub = 1'b1; arith = 1'b1; ar_we_d = 1'b1; end
      OP_ADDAI: begin opa = tgt_ar; opb = imm_sx; arith = 1'b1; ar_we_d = 1'b1; end
      OP_SUBAI: begin opa = tgt_ar; opb = imm_sx; sub = 1'b1; arith = 1'b1; ar_we_d = 1'b1; end
      OP_LEA, OP_LDA: begin opa = src_ar; opb = imm_sx; arith = 1'b1; ar_we_d = 1'b1; end
      OP_ADR:   begin opa = pc;     opb = imm_sx; arith = 1'b1; ar_we_d = 1'b1; end
      OP_CMPA:  begin opa = tgt_ar; opb = src_ar; sub = 1'b1; arith = 1'b1; sr_we = 1'b1; end
      // ARt + 0 yields the operand itself with C=V=0, which is exactly the test result.
      OP_TSTA:  begin opa = tgt_ar; arith = 1'b1; sr_we = 1'b1; end
      default: ;
    endcase
  end

  assign wide   = sub ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});
  assign res    = wide[ADDR_W-1:0];
  assign v_flag = ovf(opa[ADDR_W-1], opb[ADDR_W-1], res[ADDR_W-1], sub);

  always_comb begin
    flags = '0;
    if (arith) begin
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_N] = res[ADDR_W-1];
      flags[FLAG_C] = wide[ADDR_W];
      flags[FLAG_V] = v_flag;
    end
  end

  assign ar_result = use_mov ? mov_ar : res;

`ifdef AMBER_AR_WRAP_TRAP_EN
  // Address ops treat ARt/ARs/pc as unsigned and the offset with its own sign,
  // so the true wrap test is a two-guard-bit range check rather than raw carry.
  logic [ADDR_W+1:0] span;
  logic              chk_u;
  logic              chk_s;
  logic              wrap;

  assign chk_u = op inside {OP_ADDAU, OP_SUBAU, OP_ADDAI, OP_SUBAI, OP_LEA, OP_ADR};
  assign chk_s = op inside {OP_ADDAS, OP_SUBAS};
  assign span  = sub ? ({2'b00, opa} - {{2{opb[ADDR_W-1]}}, opb})
                     : ({2'b00, opa} + {{2{opb[ADDR_W-1]}}, opb});
  assign wrap  = (chk_u && (span[ADDR_W+1:ADDR_W] != 2'b00)) || (chk_s && v_flag);
  assign fault = wrap;
  assign ar_we = ar_we_d & ~wrap;
`else
  assign fault = 1'b0;
  assign ar_we = ar_we_d;
`endif

endmodule

// File: rtl/ex_ar_alu_pipe.sv
// Pipelined AR ALU: ar_alu_core computes in stage 1, later stages only delay.
// Optional feature macro: AMBER_AR_WRAP_TRAP_EN (address wrap trap, see ar_alu_core).
module ex_ar_alu_pipe
  import amber_ar_pkg::*;
#(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 24,
  parameter int IMM_W  = 14,
  parameter int STAGES = 2
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_valid,
  input  ar_op_t              iw_op,
  input  logic                iw_half,
  input  logic [ADDR_W-1:0]   iw_pc,
  input  logic [IMM_W-1:0]    iw_imm,
  input  logic [DATA_W-1:0]   iw_src_gp_val,
  input  logic [ADDR_W-1:0]   iw_src_ar_val,
  input  logic [ADDR_W-1:0]   iw_tgt_ar_val,
  input  logic [7:0]          iw_tag,
  input  logic                iw_stall,
  input  logic                iw_flush,
  output logic                ow_valid,
  output logic [7:0]          ow_tag,
  output logic [ADDR_W-1:0]   ow_ar_result,
  output logic                ow_ar_we,
  output logic [DATA_W-1:0]   ow_result,
  output logic                ow_gp_we,
  output logic [3:0]          ow_flags,
  output logic                ow_sr_we,
  output logic                ow_fault
);

  logic [ADDR_W-1:0] core_ar;
  logic [DATA_W-1:0] core_dr;
  ar_ctrl_t          core_ctrl;

  logic [ADDR_W-1:0] ar_p   [STAGES];
  logic [DATA_W-1:0] dr_p   [STAGES];
  ar_ctrl_t          ctrl_p [STAGES];
  logic [STAGES-1:0] vld_p;

  ar_alu_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .op        (iw_op),
    .half      (iw_half),
    .pc        (iw_pc),
    .imm       (iw_imm),
    .src_gp    (iw_src_gp_val),
    .src_ar    (iw_src_ar_val),
    .tgt_ar    (iw_tgt_ar_val),
    .ar_result (core_ar),
    .result    (core_dr),
    .flags     (core_ctrl.flags),
    .ar_we     (core_ctrl.ar_we),
    .gp_we     (core_ctrl.gp_we),
    .sr_we     (core_ctrl.sr_we),
    .fault     (core_ctrl.fault)
  );

  assign core_ctrl.tag = iw_tag;

  // Stage 1..STAGES valid chain: flush beats stall; an input beside flush is lost.
  always_ff @(posedge iw_clk) begin
    if (iw_rst || iw_flush) begin
      vld_p <= '0;
    end else if (!iw_stall) begin
      vld_p[0] <= iw_valid;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage 1..STAGES payload: stage 1 latches the core result, the rest shift.
  always_ff @(posedge iw_clk) begin
    if (!iw_stall) begin
      ar_p[0]   <= core_ar;
      dr_p[0]   <= core_dr;
      ctrl_p[0] <= core_ctrl;
      for (int i = 1; i < STAGES; i++) begin
        ar_p[i]   <= ar_p[i-1];
        dr_p[i]   <= dr_p[i-1];
        ctrl_p[i] <= ctrl_p[i-1];
      end
    end
  end

  // Output boundary: payload is never reset, so every field is gated by valid.
  assign ow_valid     = vld_p[STAGES-1];
  assign ow_tag       = ow_valid ? ctrl_p[STAGES-1].tag   : '0;
  assign ow_ar_result = ow_valid ? ar_p[STAGES-1]         : '0;
  assign ow_result    = ow_valid ? dr_p[STAGES-1]         : '0;
  assign ow_flags     = ow_valid ? ctrl_p[STAGES-1].flags : '0;
  assign ow_ar_we     = ow_valid & ctrl_p[STAGES-1].ar_we;
  assign ow_gp_we     = ow_valid & ctrl_p[STAGES-1].gp_we;
  assign ow_sr_we     = ow_valid & ctrl_p[STAGES-1].sr_we;
  assign ow_fault     = ow_valid & ctrl_p[STAGES-1].fault;

endmodule

// File: tb/tb_ex_ar_alu_pipe.sv
// Scoreboard bench for ex_ar_alu_pipe: directed ops push expected results,
// an independent negedge monitor pops and compares each presented result.
module tb_ex_ar_alu_pipe;
  import amber_ar_pkg::*;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 24;
  localparam int IMM_W  = 14;
  localparam int STAGES = 3;
`ifdef AMBER_AR_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              iw_valid;
  ar_op_t            iw_op;
  logic              iw_half;
  logic [ADDR_W-1:0] iw_pc;
  logic [IMM_W-1:0]  iw_imm;
  logic [DATA_W-1:0] iw_src_gp_val;
  logic [ADDR_W-1:0] iw_src_ar_val;
  logic [ADDR_W-1:0] iw_tgt_ar_val;
  logic [7:0]        iw_tag;
  logic              iw_stall;
  logic              iw_flush;
  logic              ow_valid;
  logic [7:0]        ow_tag;
  logic [ADDR_W-1:0] ow_ar_result;
  logic              ow_ar_we;
  logic [DATA_W-1:0] ow_result;
  logic              ow_gp_we;
  logic [3:0]        ow_flags;
  logic              ow_sr_we;
  logic              ow_fault;

  ex_ar_alu_pipe #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .IMM_W (IMM_W), .STAGES (STAGES)
  ) dut (
    .iw_clk        (clk),
    .iw_rst        (rst),
    .iw_valid      (iw_valid),
    .iw_op         (iw_op),
    .iw_half       (iw_half),
    .iw_pc         (iw_pc),
    .iw_imm        (iw_imm),
    .iw_src_gp_val (iw_src_gp_val),
    .iw_src_ar_val (iw_src_ar_val),
    .iw_tgt_ar_val (iw_tgt_ar_val),
    .iw_tag        (iw_tag),
    .iw_stall      (iw_stall),
    .iw_flush      (iw_flush),
    .ow_valid      (ow_valid),
    .ow_tag        (ow_tag),
    .ow_ar_result  (ow_ar_result),
    .ow_ar_we      (ow_ar_we),
    .ow_result     (ow_result),
    .ow_gp_we      (ow_gp_we),
    .ow_flags      (ow_flags),
    .ow_sr_we      (ow_sr_we),
    .ow_fault      (ow_fault)
  );

  typedef struct {
    logic [7:0]        tag;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] res;
    logic              ar_we, gp_we, sr_we, fault;
    logic [3:0]        flags;
    bit                chk_ar, chk_res, chk_flags, chk_we;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  logic held  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] tag, input logic [ADDR_W-1:0] ar,
                              input logic [DATA_W-1:0] res, input logic arwe,
                              input logic gpwe, input logic srwe, input logic [3:0] flags,
                              input logic fault, input bit cka, input bit ckr, input bit ckf);
    exp_t x;
    x.tag = tag; x.ar = ar; x.res = res; x.ar_we = arwe; x.gp_we = gpwe;
    x.sr_we = srwe; x.flags = flags; x.fault = fault;
    x.chk_ar = cka; x.chk_res = ckr; x.chk_flags = ckf; x.chk_we = 1'b1;
    return x;
  endfunction

  // A held output (stall at the last edge) is the same result, not a new one.
  always @(posedge clk) held <= iw_stall && !iw_flush && !rst;

  always @(negedge clk) begin
    if (ow_valid && !held) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got tag %h expected no result", ow_tag);
      end else begin
        e = sb.pop_front();
        check("tag", 96'(ow_tag), 96'(e.tag));
        if (e.chk_ar)    check("ar_result", 96'(ow_ar_result), 96'(e.ar));
        if (e.chk_res)   check("result", 96'(ow_result), 96'(e.res));
        if (e.chk_flags) check("flags", 96'(ow_flags), 96'(e.flags));
        if (e.chk_we) begin
          check("ar_we", 96'(ow_ar_we), 96'(e.ar_we));
          check("fault", 96'(ow_fault), 96'(e.fault));
        end
        check("gp_we", 96'(ow_gp_we), 96'(e.gp_we));
        check("sr_we", 96'(ow_sr_we), 96'(e.sr_we));
      end
    end else if (ow_valid === 1'b0) begin
      check("idle_quiet", {ow_tag, ow_ar_we, ow_gp_we, ow_sr_we, ow_fault, ow_flags,
                           ow_ar_result, ow_result}, 96'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input ar_op_t op, input logic half, input logic [ADDR_W-1:0] pc,
                      input logic [IMM_W-1:0] imm, input logic [DATA_W-1:0] gp,
                      input logic [ADDR_W-1:0] ars, input logic [ADDR_W-1:0] art,
                      input logic [7:0] tag, input bit push, input exp_t x);
    iw_valid = 1'b1; iw_op = op; iw_half = half; iw_pc = pc; iw_imm = imm;
    iw_src_gp_val = gp; iw_src_ar_val = ars; iw_tgt_ar_val = art; iw_tag = tag;
    if (push) sb.push_back(x);
    step();
  endtask

  task automatic idle(input int n);
    iw_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  exp_t x;
  logic [95:0] snap;
  int lat;

  initial begin
    rst = 1'b1; iw_valid = 1'b0; iw_op = OP_MOVA; iw_half = 1'b0; iw_pc = '0; iw_imm = '0;
    iw_src_gp_val = '0; iw_src_ar_val = '0; iw_tgt_ar_val = '0; iw_tag = '0;
    iw_stall = 1'b0; iw_flush = 1'b0;
    repeat (3) step();
    check("reset_valid", 96'(ow_valid), 96'd0);
    check("reset_outs", {ow_tag, ow_ar_we, ow_gp_we, ow_sr_we, ow_fault, ow_flags}, 96'd0);
    rst = 1'b0;
    step();

    // First op also measures latency.
    send(OP_MOVA, 1'b0, '0, '0, 24'hAAAAAA, '0, 48'h111122333344, 8'h01, 1,
         mk(8'h01, 48'h111122AAAAAA, '0, 1, 0, 0, '0, 0, 1, 0, 0));
    iw_valid = 1'b0;
    lat = 1;
    while (!ow_valid && lat < 10) begin step(); lat++; end
    check("latency", 96'(lat), 96'(STAGES));
    idle(2);

    send(OP_MOVA, 1'b1, '0, '0, 24'hBBBBBB, '0, 48'h111122333344, 8'h02, 1,
         mk(8'h02, 48'hBBBBBB333344, '0, 1, 0, 0, '0, 0, 1, 0, 0));
    send(OP_MOVD, 1'b1, '0, '0, '0, 48'h123456789ABC, '0, 8'h03, 1,
         mk(8'h03, '0, 24'h123456, 0, 1, 0, '0, 0, 0, 1, 0));
    send(OP_MOVD, 1'b0, '0, '0, '0, 48'h123456789ABC, '0, 8'h04, 1,
         mk(8'h04, '0, 24'h789ABC, 0, 1, 0, '0, 0, 0, 1, 0));
    send(OP_ADDAS, 1'b0, '0, '0, 24'hFFFFFF, '0, 48'h000000000100, 8'h05, 1,
         mk(8'h05, 48'h0000000000FF, '0, 1, 0, 0, 4'b0100, 0, 1, 0, 1));
    send(OP_SUBAS, 1'b0, '0, '0, 24'hFFFFFF, '0, 48'h000000000100, 8'h06, 1,
         mk(8'h06, 48'h000000000101, '0, 1, 0, 0, 4'b0100, 0, 1, 0, 1));
    x = mk(8'h07, 48'h000000000102, '0, 1, 0, 0, 4'b0100, 0, 1, 0, 1);
    x.chk_we = !TRAP;
    send(OP_SUBAI, 1'b0, '0, 14'h3FFE, '0, '0, 48'h000000000100, 8'h07, 1, x);
    send(OP_CMPA, 1'b0, '0, '0, '0, 48'h1, 48'h2, 8'h08, 1,
         mk(8'h08, '0, '0, 0, 0, 1, 4'b0000, 0, 0, 0, 1));
    send(OP_CMPA, 1'b0, '0, '0, '0, 48'h2, 48'h1, 8'h09, 1,
         mk(8'h09, '0, '0, 0, 0, 1, 4'b0110, 0, 0, 0, 1));
    send(OP_TSTA, 1'b0, '0, '0, '0, '0, 48'h0, 8'h0A, 1,
         mk(8'h0A, '0, '0, 0, 0, 1, 4'b0001, 0, 0, 0, 1));
    send(OP_ADDAU, 1'b0, '0, '0, 24'h000001, '0, 48'hFFFFFFFFFFFF, 8'h0B, 1,
         mk(8'h0B, 48'h0, '0, !TRAP, 0, 0, 4'b0101, TRAP, 1, 0, 1));
    send(OP_SUBAU, 1'b0, '0, '0, 24'h000020, '0, 48'h000000000010, 8'h0C, 1,
         mk(8'h0C, 48'hFFFFFFFFFFF0, '0, !TRAP, 0, 0, 4'b0110, TRAP, 1, 0, 1));
    send(OP_LEA, 1'b0, '0, 14'h0010, '0, 48'h000000001000, '0, 8'h0D, 1,
         mk(8'h0D, 48'h000000001010, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    send(OP_LDA, 1'b0, '0, 14'h0008, '0, 48'h000000002000, '0, 8'h0E, 1,
         mk(8'h0E, 48'h000000002008, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    send(OP_ADR, 1'b0, 48'h000000400000, 14'h0020, '0, '0, '0, 8'h0F, 1,
         mk(8'h0F, 48'h000000400020, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    send(OP_ADDAI, 1'b0, '0, 14'h0005, '0, '0, 48'h000000000010, 8'h10, 1,
         mk(8'h10, 48'h000000000015, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    send(ar_op_t'(4'hF), 1'b0, '0, '0, 24'h1, 48'h1, 48'h1, 8'h11, 1,
         mk(8'h11, '0, '0, 0, 0, 0, '0, 0, 0, 0, 0));
    idle(STAGES + 2);

    // Stall mid-stream: A visible and frozen, B held inside, C after release.
    send(OP_ADDAI, 1'b0, '0, 14'h0001, '0, '0, 48'h000000000A00, 8'h21, 1,
         mk(8'h21, 48'h000000000A01, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    send(OP_ADDAI, 1'b0, '0, 14'h0002, '0, '0, 48'h000000000B00, 8'h22, 1,
         mk(8'h22, 48'h000000000B02, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    idle(1);
    snap = {ow_valid, ow_tag, ow_ar_result};
    iw_stall = 1'b1;
    iw_valid = 1'b1; iw_op = OP_ADDAI; iw_tag = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_frozen", {ow_valid, ow_tag, ow_ar_result}, snap);
    end
    iw_stall = 1'b0;
    send(OP_ADDAI, 1'b0, '0, 14'h0003, '0, '0, 48'h000000000C00, 8'h23, 1,
         mk(8'h23, 48'h000000000C03, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    idle(STAGES + 3);

    // Flush with stall high and two ops inside the pipe.
    send(OP_ADDAI, 1'b0, '0, 14'h0001, '0, '0, 48'h1, 8'h31, 0, x);
    send(OP_ADDAI, 1'b0, '0, 14'h0001, '0, '0, 48'h2, 8'h32, 0, x);
    iw_stall = 1'b1; iw_flush = 1'b1; iw_valid = 1'b1; iw_tag = 8'h33;
    step();
    iw_stall = 1'b0; iw_flush = 1'b0; iw_valid = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      check("flush_no_valid", 96'(ow_valid), 96'd0);
      step();
    end
    send(OP_ADDAI, 1'b0, '0, 14'h0004, '0, '0, 48'h000000000D00, 8'h34, 1,
         mk(8'h34, 48'h000000000D04, '0, 1, 0, 0, 4'b0000, 0, 1, 0, 1));
    idle(STAGES + 2);

    // Reset mid-operation discards the in-flight result.
    send(OP_ADDAI, 1'b0, '0, 14'h0001, '0, '0, 48'h5, 8'h41, 0, x);
    iw_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      check("reset_drop", 96'(ow_valid), 96'd0);
      step();
    end
    send(OP_MOVA, 1'b0, '0, '0, 24'h123456, '0, 48'hABCDEF000000, 8'h42, 1,
         mk(8'h42, 48'hABCDEF123456, '0, 1, 0, 0, '0, 0, 1, 0, 0));
    iw_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    idle(2);
    check("scoreboard_drained", 96'(sb.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_ar_alu_pipe.md
# ex_ar_alu_pipe

Parametrised, pipelined address-register ALU for the amber execute stage. It computes AR arithmetic (MOVA/MOVD half-moves, unsigned/signed register adds, immediate adds, LEA, ADR, CMPA/TSTA) over a configurable address/data width with a configurable pipeline depth. Stall and flush are honoured per stage, and signed/unsigned overflow flags are produced. It sits beside the GP ALU inside the execute stage and feeds the MO/WB stages with AR, DR and SR write-backs.

## Interface
- ADDR_W, 48: address register width; must equal 2*DATA_W.
- DATA_W, 24: data register width.
- IMM_W, 14: widest immediate; narrower immediates are sign-extended by the caller to IMM_W.
- STAGES, 2: pipeline depth, 1..4; result latency in cycles.

- iw_clk  in  1  clock.
- iw_rst  in  1  synchronous, active-high reset.
- iw_valid  in  1  operation present this cycle.
- iw_op  in  4  op code, `ar_op_t` from package.
- iw_half  in  1  half select for MOVA/MOVD: 0 = low, 1 = high.
- iw_pc  in  ADDR_W  PC of the instruction, used by ADR.
- iw_imm  in  IMM_W  sign-extended immediate.
- iw_src_gp_val  in  DATA_W  DRs value.
- iw_src_ar_val  in  ADDR_W  ARs value.
- iw_tgt_ar_val  in  ADDR_W  ARt value.
- iw_tag  in  8  opaque tag; passed through unchanged.
- iw_stall  in  1  hold every stage.
- iw_flush  in  1  kill every in-flight operation.
- ow_valid  out  1  result valid.
- ow_tag  out  8  tag of the result.
- ow_ar_result  out  ADDR_W  AR write value or effective address.
- ow_ar_we  out  1  AR write enable.
- ow_result  out  DATA_W  DR write value (MOVD).
- ow_gp_we  out  1  DR write enable.
- ow_flags  out  4  {V,C,N,Z}; Z is bit 0.
- ow_sr_we  out  1  flag write enable (CMPA/TSTA).
- ow_fault  out  1  address wrap trap; see Configuration.

## Operation
- Ops: MOVAL/MOVAH replace the low/high DATA_W half of ARt with DRs. MOVDL/MOVDH output the low/high half of ARs on ow_result.
- ADDAU/SUBAU: ARt ± zero-extended DRs. ADDAS/SUBAS: ARt ± sign-extended DRs.
- ADDAI/SUBAI: ARt ± sext(imm). LEA: ARs + sext(imm), ar_we=1. LDA: same address as LEA; ar_we=1 and the value is assembled later.
- ADR: pc + sext(imm).
- CMPA: ARt − ARs, flags only. TSTA: flags from ARt (Z = ARt==0, N = msb, C=V=0).
- All arithmetic is computed in ADDR_W+1 bits. C = carry out (borrow for subtract). V = signed overflow of the ADDR_W result. Default behaviour wraps modulo 2^ADDR_W.
- Write enables are decoded per op. Reserved op codes produce valid with all write enables 0.
- The computation is done in stage 1; stages 2..STAGES are pure register delay of payload and valid.

## Timing
- Latency is exactly STAGES cycles from an iw_valid cycle to ow_valid, with no back-pressure.
- Reset: every stage valid=0. All outputs are 0, including flags, fault and tag.
- Stall: all stages hold and new input is ignored. Outputs stay stable while stalled.
- Flush: all stage valids clear on the next edge. Payload registers are don't-care.
- Flush together with stall: flush wins.
- An input in the same cycle as flush is dropped.
- Write enables and ow_fault are qualified by valid, so they are 0 whenever ow_valid=0.
- Reset asserted mid-operation discards all in-flight results within one cycle.

## Configuration
- AMBER_AR_WRAP_TRAP_EN
  - Defined: an AR write whose unsigned (ADDAU/SUBAU/ADDAI/SUBAI/LEA/ADR) or signed (ADDAS/SUBAS) result wraps past 2^ADDR_W raises ow_fault with the result. ow_ar_we is forced to 0 for that result.
  - Undefined: ow_fault is tied 0 and results wrap silently.

## Structure
- Package `amber_ar_pkg`: `ar_op_t` enum (4-bit), flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3, and the stage payload struct.
- Sub-module `ar_alu_core`: combinational stage-1 datapath (op decode, extension, ADDR_W+1 add/sub, flags, wrap detect). The top holds the pipeline registers and stall/flush control.

## Test plan
- MOVAL, DRs=AAAAAA, ARt=111122_333344 → after STAGES cycles: ar_we=1, ar_result=111122_AAAAAA. MOVAH with DRs=BBBBBB → BBBBBB_333344.
- ADDAS, ARt=000000_000100, DRs=FFFFFF → 000000_0000FF. SUBAS with the same operands → 000000_000101. SUBAI with imm=−2 → 000000_000102.
- CMPA, ARs=1, ARt=2 → sr_we=1, flags Z=0, N=0, C=0. CMPA with ARs=2, ARt=1 → N=1, C=1. TSTA with ARt=0 → Z=1.
- Back-to-back ops A, B, C with stall asserted 3 cycles mid-stream → outputs frozen during the stall, then A, B, C emerge in order with no loss or duplication.
- Flush asserted with two ops in flight and stall high → ow_valid stays 0 for both. The next op completes normally.
- ADDAU, ARt=FFFFFF_FFFFFF, DRs=000001:
  - With AMBER_AR_WRAP_TRAP_EN: fault=1, ar_we=0.
  - Without: ar_result=0, C=1, ar_we=1, fault=0.
